// File: rtl/spybuffer_event_arbiter_pkg.sv
// Shared types and constants for the SpyBuffer event arbiter.
// The FLUSH state only exists when ARB_TIMEOUT_EN is defined.
package l0mdt_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1
`ifdef ARB_TIMEOUT_EN
        ,
        ST_FLUSH = 2'd2
`endif
    } arb_state_t;

    // Position of the end-of-event flag within a word.
    function automatic int eoe_bit(input int data_width);
        return data_width - 1;
    endfunction

    // Synthetic flush word: EOE flag set, every payload bit cleared.
    localparam logic FLUSH_EOE  = 1'b1;
    localparam logic FLUSH_FILL = 1'b0;

endpackage

// File: rtl/spybuffer_event_arbiter_if.sv
// FIFO-side bus of the event arbiter: N first-word-fall-through inputs
// on one side, one downstream SpyBuffer write port on the other.
// master = arbiter, slave = harness FIFOs.
interface spybuffer_event_arbiter_if #(
    parameter int DATA_WIDTH = 65,
    parameter int N_INPUTS   = 4
);
    logic [N_INPUTS-1:0][DATA_WIDTH-1:0] in_data;
    logic [N_INPUTS-1:0]                 in_empty;
    logic [N_INPUTS-1:0]                 in_read_enable;
    logic [DATA_WIDTH-1:0]               out_data;
    logic                                out_write_enable;
    logic                                out_almost_full;

    modport master (
        input  in_data, in_empty, out_almost_full,
        output in_read_enable, out_data, out_write_enable
    );

    modport slave (
        output in_data, in_empty, out_almost_full,
        input  in_read_enable, out_data, out_write_enable
    );
endinterface

// File: rtl/spybuffer_event_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping.
module rr_pick #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          valid
);
    // Scan farthest-first so the nearest requester after ptr overrides.
    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        valid = |req;
        for (int k = N; k >= 1; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = PW'(j);
            end
        end
    end
endmodule

// File: rtl/spybuffer_event_arbiter.sv
// Event-level round-robin arbiter between input SpyBuffer FIFOs and one
// downstream SpyBuffer. A grant is held for a whole event (until a word
// with the EOE flag is popped); one word per cycle under almost-full
// backpressure. Optional mid-event starvation timeout: ARB_TIMEOUT_EN.
module spybuffer_event_arbiter
    import l0mdt_arb_pkg::*;
#(
    parameter  int DATA_WIDTH     = 65,
    parameter  int N_INPUTS       = 4,
    parameter  int COUNT_WIDTH    = 32,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int PW             = $clog2(N_INPUTS)
) (
    input  logic                   clock,
    input  logic                   reset,
    spybuffer_event_arbiter_if.master bus,
    output logic [N_INPUTS-1:0]    grant,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] event_count,
    output logic                   timeout_error,
    output logic [PW-1:0]          timeout_port
);
    localparam int EOE = eoe_bit(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] FLUSH_WORD = {FLUSH_EOE, {(DATA_WIDTH-1){FLUSH_FILL}}};

    arb_state_t            state;
    logic [PW-1:0]         ptr;
    logic [PW-1:0]         g_idx;
    logic [N_INPUTS-1:0]   pick_oh;
    logic [PW-1:0]         pick_idx;
    logic                  pick_vld;
    logic                  pop;
    logic [DATA_WIDTH-1:0] g_word;

    rr_pick #(.N(N_INPUTS)) u_pick (
        .req   (~bus.in_empty),
        .ptr   (ptr),
        .grant (pick_oh),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    // Pop is combinational so the word is taken the same cycle it is seen;
    // gated by reset so no word is silently dropped while clearing.
    assign g_word             = bus.in_data[g_idx];
    assign pop                = !reset && (state == ST_GRANT) &&
                                !bus.in_empty[g_idx] && !bus.out_almost_full;
    assign bus.in_read_enable = grant & {N_INPUTS{pop}};

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] starve;
`else
    assign timeout_error = 1'b0;
    assign timeout_port  = '0;
`endif

    // Arbitration FSM with registered grant, forwarded word and counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            state                <= ST_IDLE;
            ptr                  <= PW'(N_INPUTS - 1);
            g_idx                <= '0;
            grant                <= '0;
            busy                 <= 1'b0;
            bus.out_data         <= '0;
            bus.out_write_enable <= 1'b0;
            event_count          <= '0;
`ifdef ARB_TIMEOUT_EN
            starve               <= '0;
            timeout_error        <= 1'b0;
            timeout_port         <= '0;
`endif
        end else begin
            bus.out_write_enable <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        grant <= pick_oh;
                        g_idx <= pick_idx;
                        busy  <= 1'b1;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (pop) begin
                        bus.out_data         <= g_word;
                        bus.out_write_enable <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        starve               <= '0;
`endif
                        if (g_word[EOE]) begin
                            event_count <= event_count + COUNT_WIDTH'(1);
                            ptr         <= g_idx;
                            grant       <= '0;
                            busy        <= 1'b0;
                            state       <= ST_IDLE;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (bus.in_empty[g_idx]) begin
                        // The TIMEOUT_CYCLES-th consecutive empty cycle aborts the event.
                        if (starve >= TW'(TIMEOUT_CYCLES - 1)) begin
                            state         <= ST_FLUSH;
                            timeout_error <= 1'b1;
                            timeout_port  <= g_idx;
                            starve        <= '0;
                        end else begin
                            starve <= starve + TW'(1);
                        end
                    end
`endif
                end
`ifdef ARB_TIMEOUT_EN
                ST_FLUSH: begin
                    // Close the aborted event downstream; not counted as completed.
                    if (!bus.out_almost_full) begin
                        bus.out_data         <= FLUSH_WORD;
                        bus.out_write_enable <= 1'b1;
                        ptr                  <= g_idx;
                        grant                <= '0;
                        busy                 <= 1'b0;
                        state                <= ST_IDLE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spybuffer_event_arbiter.sv
// Directed bench for spybuffer_event_arbiter. Harness FIFOs are bench
// queues; a cycle model of the arbitration rules predicts pops, writes,
// grant and counters each cycle. Timeout scenario runs with ARB_TIMEOUT_EN.
module tb_spybuffer_event_arbiter;
    localparam int N  = 4;
    localparam int DW = 65;
    localparam int CW = 8;
    localparam int TO = 16;
    typedef logic [DW-1:0] word_t;
    localparam word_t FLUSH_W = {1'b1, 64'd0};

    logic          clock = 1'b0;
    logic          reset;
    logic [N-1:0]  grant;
    logic          busy;
    logic [CW-1:0] event_count;
    logic          timeout_error;
    logic [1:0]    timeout_port;

    spybuffer_event_arbiter_if #(.DATA_WIDTH(DW), .N_INPUTS(N)) bus ();

    spybuffer_event_arbiter #(
        .DATA_WIDTH(DW), .N_INPUTS(N), .COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus), .grant(grant), .busy(busy),
        .event_count(event_count), .timeout_error(timeout_error), .timeout_port(timeout_port)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Harness FIFOs and model state
    word_t         q[N][$];
    int            m_owner, m_last, m_starve, m_tport;
    bit            m_flush, m_terr;
    logic [CW-1:0] m_cnt;
    logic          m_we;
    word_t         m_data;

    // Per-test statistics
    int            cyc, n_writes, first_grant, last_wr, prev_wr, min_gap, max_gap, n_flush;
    logic [31:0]   order_code;
    logic [N-1:0]  prev_grant;

    function automatic word_t mkword(input int inp, input int seq, input bit eoe);
        return {eoe, inp[7:0], 56'(seq)};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic clear_stats();
        n_writes = 0; first_grant = -1; last_wr = -1; prev_wr = -1;
        min_gap = 1000; max_gap = 0; n_flush = 0; order_code = '0;
    endtask

    task automatic model_reset();
        m_owner = -1; m_last = N - 1; m_starve = 0; m_tport = 0;
        m_flush = 0; m_terr = 0; m_cnt = '0; m_we = 1'b0; m_data = '0;
    endtask

    // One clock: drive inputs, check the pop strobes, advance the model,
    // then check every registered output after the edge.
    task automatic step(input bit rst_i, input bit af_i);
        logic [N-1:0] exp_rd, act_rd;
        bit found;
        reset = rst_i;
        bus.out_almost_full = af_i;
        for (int i = 0; i < N; i++) begin
            bus.in_empty[i] = (q[i].size() == 0);
            bus.in_data[i]  = (q[i].size() == 0) ? '0 : q[i][0];
        end
        #1;
        exp_rd = '0;
        if (!rst_i && !m_flush && m_owner >= 0 && !bus.in_empty[m_owner] && !af_i)
            exp_rd[m_owner] = 1'b1;
        act_rd = bus.in_read_enable;
        check("in_read_enable", act_rd, exp_rd);
        if (rst_i) begin
            model_reset();
        end else begin
            m_we = 1'b0;
            if (m_flush) begin
                if (!af_i) begin
                    m_we = 1'b1; m_data = FLUSH_W; m_last = m_owner;
                    m_owner = -1; m_flush = 0; m_starve = 0;
                end
            end else if (m_owner < 0) begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    if (!found && q[(m_last + k) % N].size() != 0) begin
                        m_owner = (m_last + k) % N;
                        found = 1;
                    end
                end
            end else if (exp_rd != '0) begin
                m_we = 1'b1; m_data = q[m_owner][0]; m_starve = 0;
                if (m_data[DW-1]) begin
                    m_cnt = m_cnt + 1'b1; m_last = m_owner; m_owner = -1;
                end
            end else if (bus.in_empty[m_owner]) begin
`ifdef ARB_TIMEOUT_EN
                m_starve++;
                if (m_starve >= TO) begin
                    m_flush = 1; m_terr = 1; m_tport = m_owner;
                end
`endif
            end
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) if (act_rd[i] && q[i].size() != 0) void'(q[i].pop_front());
        check("out_write_enable", bus.out_write_enable, m_we);
        check("out_data", bus.out_data, m_data);
        check("grant", grant, (m_owner >= 0) ? (4'b1 << m_owner) : 4'b0);
        check("busy", busy, m_owner >= 0);
        check("event_count", event_count, m_cnt);
        check("timeout_error", timeout_error, m_terr);
        check("timeout_port", timeout_port, m_tport[1:0]);
        if (bus.out_write_enable) begin
            n_writes++;
            if (prev_wr >= 0) begin
                if (cyc - prev_wr < min_gap) min_gap = cyc - prev_wr;
                if (cyc - prev_wr > max_gap) max_gap = cyc - prev_wr;
            end
            prev_wr = cyc; last_wr = cyc;
            if (bus.out_data == FLUSH_W) n_flush++;
        end
        if (grant != '0 && prev_grant == '0) begin
            for (int i = 0; i < N; i++) if (grant[i]) order_code = (order_code << 4) | 32'(i);
            if (first_grant < 0) first_grant = cyc;
        end
        prev_grant = grant;
        cyc++;
        @(negedge clock);
    endtask

    task automatic drain(input int budget);
        bit done;
        done = 0;
        for (int n = 0; n < budget && !done; n++) begin
            if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 &&
                q[3].size() == 0 && m_owner < 0 && !m_flush) done = 1;
            else step(1'b0, 1'b0);
        end
        check("drain_done", done, 1'b1);
    endtask

    task automatic push_event(input int inp, input int len, input int base);
        for (int s = 0; s < len; s++) q[inp].push_back(mkword(inp, base + s, s == len - 1));
    endtask

    initial begin
        reset = 1'b1;
        bus.in_empty = '1;
        bus.in_data = '0;
        bus.out_almost_full = 1'b0;
        prev_grant = '0;
        cyc = 0;
        model_reset();
        clear_stats();
        @(negedge clock);

        // Reset state
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("rst_grant", grant, 4'b0);
        check("rst_we", bus.out_write_enable, 1'b0);
        check("rst_count", event_count, 8'd0);

        // Inputs 0 and 2 each hold a 3-word event at reset release
        push_event(0, 3, 0);
        push_event(2, 3, 0);
        step(1'b1, 1'b0);
        clear_stats();
        drain(100);
        check("t1_writes", n_writes, 6);
        check("t1_count", event_count, 8'd2);
        check("t1_order", order_code, 32'h02);
        check("t1_span", last_wr - first_grant + 1, 8);

        // All inputs loaded with single-word events
        step(1'b1, 1'b0);
        clear_stats();
        for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push_event(i, 1, r);
        drain(100);
        check("t2_order", order_code, 32'h01230123);
        check("t2_min_gap", min_gap, 2);
        check("t2_max_gap", max_gap, 2);
        check("t2_count", event_count, 8'd8);

        // Almost-full held 5 cycles mid-event
        step(1'b1, 1'b0);
        clear_stats();
        push_event(1, 6, 0);
        for (int s = 0; s < 3; s++) step(1'b0, 1'b0);
        begin
            int w0;
            w0 = n_writes;
            for (int s = 0; s < 5; s++) step(1'b0, 1'b1);
            check("t3_af_writes", n_writes - w0, 0);
        end
        drain(100);
        check("t3_writes", n_writes, 6);
        check("t3_last_word", bus.out_data, mkword(1, 5, 1));

        // Input 1 runs dry mid-event while input 3 waits
        step(1'b1, 1'b0);
        clear_stats();
        q[1].push_back(mkword(1, 0, 0));
        q[1].push_back(mkword(1, 1, 0));
        push_event(3, 1, 0);
        for (int s = 0; s < 13; s++) step(1'b0, 1'b0);
        check("t4_held_grant", grant, 4'b0010);
        check("t4_mid_writes", n_writes, 2);
        q[1].push_back(mkword(1, 2, 0));
        q[1].push_back(mkword(1, 3, 1));
        drain(100);
        check("t4_order", order_code, 32'h13);
        check("t4_writes", n_writes, 5);
        check("t4_count", event_count, 8'd2);

        // Reset mid-event
        step(1'b1, 1'b0);
        clear_stats();
        push_event(2, 5, 0);
        for (int s = 0; s < 3; s++) step(1'b0, 1'b0);
        push_event(0, 1, 0);
        step(1'b1, 1'b0);
        check("t5_rst_grant", grant, 4'b0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_we", bus.out_write_enable, 1'b0);
        check("t5_rst_data", bus.out_data, 65'd0);
        check("t5_rst_count", event_count, 8'd0);
        clear_stats();
        drain(100);
        check("t5_order", order_code, 32'h02);
        check("t5_writes", n_writes, 4);

        // event_count wraps
        step(1'b1, 1'b0);
        clear_stats();
        for (int e = 0; e < 257; e++) push_event(0, 1, e);
        drain(2000);
        check("t6_wrap_count", event_count, 8'd1);

`ifdef ARB_TIMEOUT_EN
        // Input 2 starves mid-event
        step(1'b1, 1'b0);
        clear_stats();
        q[2].push_back(mkword(2, 0, 0));
        q[2].push_back(mkword(2, 1, 0));
        push_event(3, 1, 0);
        drain(200);
        check("t7_terr", timeout_error, 1'b1);
        check("t7_tport", timeout_port, 2'd2);
        check("t7_flush_words", n_flush, 1);
        check("t7_writes", n_writes, 4);
        check("t7_order", order_code, 32'h23);
        check("t7_count", event_count, 8'd1);
        step(1'b1, 1'b0);
        check("t7_rst_terr", timeout_error, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/spybuffer_event_arbiter.md
# spybuffer_event_arbiter

Event-level round-robin arbiter between the input SpyBuffer FIFOs of a test/top-level harness and a single downstream consumer (DUT input or output SpyBuffer). Holds a grant for a whole event, delimited by the end-of-event (EOE) flag in the data MSB. Forwards one word per cycle under output almost-full backpressure. Reports the current grant and a count of completed events.

## Interface
Parameters:
- DATA_WIDTH, 65, word width including the EOE flag at bit DATA_WIDTH-1
- N_INPUTS, 4, number of requesting FIFOs (2..16)
- COUNT_WIDTH, 32, width of event_count
- TIMEOUT_CYCLES, 1024, mid-event starvation limit (used only with the timeout macro)

Ports:
- clock  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- in_data  in  [N_INPUTS] x DATA_WIDTH  first-word-fall-through read data of each input FIFO
- in_empty  in  [N_INPUTS] x 1  input FIFO empty
- in_read_enable  out  [N_INPUTS] x 1  pop strobe per input FIFO
- out_data  out  DATA_WIDTH  registered forwarded word
- out_write_enable  out  1  registered write strobe to downstream FIFO
- out_almost_full  in  1  downstream FIFO almost full (slack >= 2 entries)
- grant  out  N_INPUTS  one-hot current grant, 0 when idle
- busy  out  1  high in any state other than IDLE
- event_count  out  COUNT_WIDTH  events completed with a real EOE, wraps
- timeout_error  out  1  sticky starvation flag (macro only)
- timeout_port  out  $clog2(N_INPUTS)  input that timed out (macro only)

## Operation
- FSM states: IDLE, GRANT, FLUSH (FLUSH exists only with the macro).
- IDLE: if any in_empty[i]==0, pick the first non-empty input scanning ptr+1, ptr+2, … modulo N_INPUTS. Register grant, go to GRANT. No pop in IDLE.
- ptr is the last granted index. Reset value is N_INPUTS-1, so input 0 has first priority after reset.
- GRANT: in_read_enable[g] = !in_empty[g] && !out_almost_full, combinational. All other in_read_enable are 0 in all states.
- On a pop: out_data <= in_data[g]; out_write_enable <= 1. Without a pop, out_write_enable <= 0 and out_data holds its value.
- Popped word with EOE=1: event_count++, ptr <= g, next state IDLE, grant cleared.
- Requests from other inputs during GRANT are ignored until the event ends. There is no preemption.
- Word bits are forwarded unmodified, EOE included.

## Timing
- Reset values: in_read_enable=0, out_data=0, out_write_enable=0, grant=0, busy=0, event_count=0, timeout_error=0, timeout_port=0, state IDLE, ptr=N_INPUTS-1.
- Latency: pop at cycle t gives out_write_enable and out_data at t+1.
- Throughput: an event of L words occupies L+1 cycles (1 arbitration bubble). This holds even when the same input re-wins immediately.
- Backpressure: out_almost_full sampled high gives no pop that cycle. At most 1 word is in flight after assertion.
- Input empty mid-event: grant is held and no pop occurs.
- Single-word event (EOE on first word): GRANT lasts exactly 1 cycle.
- event_count wraps from 2^COUNT_WIDTH-1 to 0.
- Reset mid-event: all state is cleared the next cycle. The partial event is not completed downstream.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A starvation counter increments in GRANT while in_empty[g]=1 and clears on every pop.
  - When it reaches TIMEOUT_CYCLES, the FSM enters FLUSH and sets timeout_error=1 (sticky until reset) and timeout_port=g.
  - FLUSH waits for !out_almost_full, then writes one synthetic word (EOE=1, all other bits 0). It then sets ptr <= g and goes to IDLE.
  - event_count is not incremented for the synthetic word.
- ARB_TIMEOUT_EN undefined: no counter and no FLUSH state. timeout_error and timeout_port are tied to 0, and a grant is held indefinitely.

## Structure
- Package l0mdt_arb_pkg holds: FSM state enum; EOE_BIT = DATA_WIDTH-1 helper function; synthetic flush word constant.
- Sub-module rr_pick: combinational round-robin picker taking request vector and ptr, returning one-hot grant, index and any-valid.

## Test plan
- Inputs 0 and 2 each hold one 3-word event, both non-empty at reset release -> input 0 forwarded (3 writes), 1 idle cycle, then input 2. event_count=2, total 8 cycles from first grant to last write.
- All 4 inputs continuously loaded with 1-word events -> grant order 0,1,2,3,0…, one write every 2 cycles.
- out_almost_full held high for 5 cycles mid-event -> no pops in those cycles. Word order and contents unchanged, no loss, no duplication.
- Input 1 empties after 2 of 4 words, refills 10 cycles later, input 3 requesting meanwhile -> grant stays on 1 until its EOE, then moves to 3.
- Reset asserted mid-event -> next cycle all outputs are at reset values. After release the first grant goes to input 0.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, input 2 stalls mid-event for 20 cycles -> timeout_error=1, timeout_port=2, one synthetic EOE word written, event_count unchanged, arbitration resumes at input 3.
